// File: rtl/servant_spi_fram_slave_if.sv
// Pin-level bundle for the FRAM emulator: SPI pads, status flags and the
// backdoor RAM port.
interface servant_spi_fram_slave_if #(
    parameter int MEM_AW = 10
);
    logic              spi_sck;
    logic              spi_ss;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              wel;
    logic              busy;
    logic [MEM_AW-1:0] bd_addr;
    logic              bd_we;
    logic [7:0]        bd_wdata;
    logic [7:0]        bd_rdata;

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, bd_addr, bd_we, bd_wdata,
        output spi_miso, spi_miso_oe, wel, busy, bd_rdata
    );

    modport master (
        output spi_sck, spi_ss, spi_mosi, bd_addr, bd_we, bd_wdata,
        input  spi_miso, spi_miso_oe, wel, busy, bd_rdata
    );
endinterface

// File: rtl/servant_spi_fram_slave.sv
// SPI mode-3 responder emulating a serial FRAM (WREN/WRDI/RDSR/READ/WRITE)
// on an on-chip byte RAM, oversampled on the system clock.
module servant_spi_fram_slave #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int MEM_AW        = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    servant_spi_fram_slave_if.slave bus
);
    localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;
    localparam int SCK  = 2;
    localparam int SS   = 1;
    localparam int MOSI = 0;
    localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_RDSR   = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    logic [7:0] mem [0:(2**MEM_AW)-1];

    logic [2:0]        meta_q, meta_d, sync_q, sync_d, hist_q, hist_d;
    logic              sck_rise_q, sck_rise_d, sck_fall_q, sck_fall_d;
    logic              ss_rise_q, ss_rise_d, ss_fall_q, ss_fall_d;
    logic [2:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        op_q, op_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        abyte_q, abyte_d;
    logic              cmd8_q, cmd8_d;
    logic              fetch_q, fetch_d;
    logic [7:0]        tx_q, tx_d;
    logic              wel_q, wel_d;
    logic              busy_q, busy_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic [7:0]        bd_rdata_q, bd_rdata_d;

    logic [7:0]        rx_byte_s;
    logic              byte_done_s;
    logic              mem_we_s;
    logic              bd_we_s;
    logic              miso_next_s;

    // Next-state logic: edge detection, bit/byte framing, opcode decode and datapath.
    always_comb begin
        meta_d      = {bus.spi_sck, bus.spi_ss, bus.spi_mosi};
        sync_d      = meta_q;
        hist_d      = sync_q;
        sck_rise_d  =  sync_q[SCK] & ~hist_q[SCK];
        sck_fall_d  = ~sync_q[SCK] &  hist_q[SCK];
        ss_rise_d   =  sync_q[SS]  & ~hist_q[SS];
        ss_fall_d   = ~sync_q[SS]  &  hist_q[SS];
        rx_byte_s   = {shift_q[6:0], hist_q[MOSI]};
        byte_done_s = sck_rise_q && (bit_cnt_q == 3'd7);
        busy_d      = ~sync_q[SS];
        bd_rdata_d  = mem[bus.bd_addr];
        bd_we_s     = bus.bd_we & ~busy_q & ~reset;
        mem_we_s    = 1'b0;
        state_d     = state_q;
        op_d        = op_q;
        abyte_d     = abyte_q;
        cmd8_d      = cmd8_q;
        fetch_d     = 1'b0;
        wel_d       = wel_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        miso_next_s = miso_q;

        if (ss_fall_q) begin
            bit_cnt_d = 3'd0;
        end else if (sck_rise_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        if (sck_rise_q) begin
            shift_d = rx_byte_s;
        end else begin
            shift_d = shift_q;
        end

        // A prefetch lands two cycles after the completing edge, well clear of the next fall.
        if (fetch_q) begin
            tx_d   = mem[addr_q];
            addr_d = addr_q + ADDR_ONE;
        end else if (sck_fall_q && (state_q == S_RDATA || state_q == S_RDSR)) begin
            miso_next_s = tx_q[7];
            tx_d        = {tx_q[6:0], 1'b0};
        end else begin
            tx_d = tx_q;
        end

        case (state_q)
            S_IDLE: begin
                if (ss_fall_q) begin
                    state_d = S_CMD;
                end else if (~sync_q[SS] && ~hist_q[SS]) begin
                    state_d = S_IGNORE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (byte_done_s) begin
                    op_d    = rx_byte_s;
                    abyte_d = 8'd0;
                    case (rx_byte_s)
                        8'h03, 8'h02: state_d = S_ADDR;
                        8'h05: begin
                            state_d = S_RDSR;
                            tx_d    = {6'b0, wel_q, 1'b0};
                        end
                        8'h06, 8'h04: begin
                            state_d = S_IGNORE;
                            cmd8_d  = 1'b1;
                        end
                        default: state_d = S_IGNORE;
                    endcase
                end else begin
                    state_d = S_CMD;
                end
            end
            S_ADDR: begin
                if (byte_done_s) begin
                    addr_d  = {addr_q[MEM_AW-9:0], rx_byte_s};
                    abyte_d = abyte_q + 8'd1;
                    if (abyte_q == 8'(ADDR_BYTES - 1)) begin
                        if (op_q == 8'h03) begin
                            state_d = S_RDATA;
                            fetch_d = 1'b1;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end else begin
                        state_d = S_ADDR;
                    end
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_WDATA: begin
                if (byte_done_s) begin
                    mem_we_s = wel_q;
                    addr_d   = addr_q + ADDR_ONE;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            S_RDATA: begin
                if (byte_done_s) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                end
            end
            S_RDSR: begin
                if (byte_done_s) begin
                    tx_d = {6'b0, wel_q, 1'b0};
                end else begin
                    tx_d = tx_d;
                end
            end
            S_IGNORE: begin
                // Any bit beyond the eighth disqualifies a WREN/WRDI frame.
                if (sck_rise_q) begin
                    cmd8_d = 1'b0;
                end else begin
                    cmd8_d = cmd8_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ss_rise_q) begin
            state_d = S_IDLE;
            cmd8_d  = 1'b0;
            fetch_d = 1'b0;
            if (state_q == S_WDATA) begin
                wel_d = 1'b0;
            end else if (state_q == S_IGNORE && cmd8_q && op_q == 8'h06) begin
                wel_d = 1'b1;
            end else if (state_q == S_IGNORE && cmd8_q && op_q == 8'h04) begin
                wel_d = 1'b0;
            end else begin
                wel_d = wel_q;
            end
        end else begin
            wel_d = wel_q;
        end

        oe_d = (state_q == S_RDATA || state_q == S_RDSR) && ~sync_q[SS];
        if (oe_d) begin
            miso_d = miso_next_s;
        end else begin
            miso_d = 1'b0;
        end
    end

    // Pin synchronizers run through reset so a frame in progress is never seen as a fresh SS fall.
    always_ff @(posedge clock) begin
        meta_q <= meta_d;
        sync_q <= sync_d;
        hist_q <= hist_d;
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            ss_rise_q  <= 1'b0;
            ss_fall_q  <= 1'b0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            op_q       <= 8'd0;
            addr_q     <= '0;
            abyte_q    <= 8'd0;
            cmd8_q     <= 1'b0;
            fetch_q    <= 1'b0;
            tx_q       <= 8'd0;
            wel_q      <= 1'b0;
            busy_q     <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            bd_rdata_q <= 8'd0;
        end else begin
            sck_rise_q <= sck_rise_d;
            sck_fall_q <= sck_fall_d;
            ss_rise_q  <= ss_rise_d;
            ss_fall_q  <= ss_fall_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            abyte_q    <= abyte_d;
            cmd8_q     <= cmd8_d;
            fetch_q    <= fetch_d;
            tx_q       <= tx_d;
            wel_q      <= wel_d;
            busy_q     <= busy_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            bd_rdata_q <= bd_rdata_d;
        end
    end

    // RAM write port: SPI data has priority; backdoor only while no frame is active.
    always_ff @(posedge clock) begin
        if (mem_we_s && !reset) begin
            mem[addr_q] <= rx_byte_s;
        end else if (bd_we_s) begin
            mem[bus.bd_addr] <= bus.bd_wdata;
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.wel         = wel_q;
    assign bus.busy        = busy_q;
    assign bus.bd_rdata    = bd_rdata_q;
endmodule

// File: doc/servant_spi_fram_slave.md
# servant_spi_fram_slave

SPI responder that emulates the serial FRAM addressed by the servant SPI master, backed by an on-chip byte RAM. Lets the SPI boot/data path be exercised in simulation and on boards without the external FRAM fitted. Oversamples SCK/SS/MOSI on the system clock, decodes the FRAM opcode set (WREN, WRDI, RDSR, READ, WRITE), and provides a backdoor port for preload and checking.

## Interface
- ADDRESS_WIDTH, 24: wire address bits after the opcode; multiple of 8, giving ADDRESS_WIDTH/8 address bytes.
- MEM_AW, 10: RAM is 2^MEM_AW bytes; the low MEM_AW bits of the received address are used, upper bits ignored.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- spi_sck  in  1  SPI clock from the master, asynchronous, mode 3 (idles high).
- spi_ss  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master-to-slave data, MSB first.
- spi_miso  out  1  slave-to-master data.
- spi_miso_oe  out  1  MISO drive enable for the pad tristate.
- wel  out  1  write-enable latch (status bit 1).
- busy  out  1  synchronized SS is low.
- bd_addr  in  MEM_AW  backdoor byte address.
- bd_we  in  1  backdoor write strobe.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  registered backdoor read data, mem[bd_addr] one cycle later.

## Operation
- Synchronizers: two flops each on sck, ss, and mosi, plus one history flop per signal. sck_rise and sck_fall are single-cycle pulses. ss_rise and ss_fall are likewise single-cycle pulses.
- Bit counter (3 bits) increments on sck_rise and clears on ss_fall. The MOSI shift register takes the synchronized mosi on each sck_rise. A byte is complete on the 8th sck_rise.
- States: IDLE, CMD, ADDR, WDATA, RDATA, RDSR, IGNORE.
- Transitions out of IDLE: ss_fall goes to CMD.
- Transitions out of CMD, on byte complete:
  - 0x03 goes to ADDR (read).
  - 0x02 goes to ADDR (write).
  - 0x05 goes to RDSR.
  - 0x06 and 0x04 go to IGNORE, with the opcode latched.
  - Any other opcode goes to IGNORE.
- ADDR shifts ADDRESS_WIDTH bits into the address register. After the last byte it goes to RDATA or WDATA according to the latched opcode.
- ss_rise in any state returns to IDLE and discards any partial byte.
- WREN/WRDI take effect on ss_rise only if exactly 8 bits were clocked: 0x06 sets wel, 0x04 clears it. Any other bit count leaves wel unchanged.
- WDATA:
  - Each complete byte writes mem[addr] if wel=1, then addr increments. The increment happens even when wel=0.
  - With wel=0, memory is unchanged.
  - wel clears on the ss_rise that ends any WRITE command that reached WDATA.
- RDATA:
  - On the byte complete that ends ADDR, read mem[addr], load the output shift register, and increment addr.
  - Each later byte complete prefetches the next byte the same way.
  - MISO shifts on sck_fall, MSB first.
- RDSR: every byte shifted out is {6'b0, wel, 1'b0}, repeating until ss_rise.
- Address wraps modulo 2^MEM_AW. Reading or writing past 2^MEM_AW-1 continues at 0.
- spi_miso_oe=1 in RDATA/RDSR while SS is low, otherwise 0. spi_miso=0 whenever spi_miso_oe=0.
- Backdoor:
  - bd_we is honoured only while busy=0. While busy=1 it is dropped, so SPI writes and backdoor writes never collide.
  - bd_rdata is always live.
- Reset:
  - All state goes to IDLE; wel=0, busy=0, spi_miso=0, spi_miso_oe=0, bd_rdata=0, bit counter 0.
  - RAM contents are not cleared.
  - If synchronized SS is low when reset deasserts, enter IGNORE and stay there until ss_rise. Decoding never starts mid-frame.

## Timing
- Edge detect latency: a pin transition produces its pulse 3 clock cycles later.
- Registered MISO changes 4 cycles after an SCK pin fall.
- SCK high and low phases must each be ≥ 6 clock cycles, i.e. master CLOCK_DIVIDER ≥ 12. Slower SCK is always valid.
- SS high time between frames ≥ 4 clock cycles.
- Memory write lands 1 cycle after the completing sck_rise. The prefetched read byte is in the shift register 2 cycles after the completing sck_rise, which is before the next sck_fall.
- wel updates 1 cycle after ss_rise. busy follows synchronized SS with 3-cycle latency.
- bd_rdata latency is 1 cycle.

## Test plan
- Preload via backdoor mem[0x010..0x013]=11,22,33,44. SPI READ 03 00 00 10, then 4 bytes -> MISO returns 11 22 33 44, spi_miso_oe=1 only during the data phase.
- WRITE with no WREN: 02 00 00 20 AA -> mem[0x020] unchanged (bd_rdata check), wel stays 0.
- WREN frame 06, then RDSR 05 xx -> returns 0x02. WRITE 02 00 00 20 AA BB -> mem[0x020]=AA, mem[0x021]=BB, wel=0 after ss_rise, RDSR returns 0x00.
- Wrap: WREN, then WRITE at 0x0003FF with data 5A A5 (MEM_AW=10) -> mem[0x3FF]=5A, mem[0x000]=A5. READ from 0x3FF returns 5A A5.
- Abort: ss_rise after 4 bits of the second data byte of a write -> only the first byte is written, state IDLE. A WREN frame with 12 bits -> wel unchanged.
- Reset asserted mid-READ with SS held low -> outputs at reset values, no decode until SS toggles high, RAM preserved. The next READ frame returns the correct data.
